reg_bank: RTL and testbench

Parametrised architectural register bank for the CPU core. It replaces the individually instantiated general-purpose and special-purpose registers with one block. The block holds NUM_GPR general registers plus SP, LR and PC, and provides two combinational read ports with write-through bypass and one write port. PC sequencing (increment / branch / branch-and-link) and SP push/pop adjustment are handled internally, so the datapath sees a single register space.

---
 rtl/reg_bank.sv | 198 +++++++++++++++++++
 tb/tb_reg_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// reg_bank
// Architectural register bank for the CPU core: NUM_GPR general registers
// plus SP, LR and PC in a single index space, with two combinational read
// ports and one write port.
//
// Register index map:
//   0 .. NUM_GPR-1 : general registers
//   NUM_GPR        : SP
//   NUM_GPR+1      : LR
//   NUM_GPR+2      : PC
//   anything above : invalid (reads return 0, writes raise wr_err)
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        asynchronous, active-low reset
//   ra_addr    read port A index        -> ra_data (combinational)
//   rb_addr    read port B index        -> rb_data (combinational)
//   we         write enable, with wa_addr / wd_data
//   pc_en      advance PC by PC_STEP
//   br_valid   load PC from br_target
//   br_link    with br_valid, LR <= PC + PC_STEP
//   sp_push    SP <= SP - SP_STEP
//   sp_pop     SP <= SP + SP_STEP
//   pc_out, sp_out, lr_out   registered PC / SP / LR
//   wr_err     one-cycle registered pulse after a write to an invalid index
module reg_bank #(
  parameter int               WIDTH    = 32,
  parameter int               NUM_GPR  = 13,
  parameter int               AW       = $clog2(NUM_GPR + 3),
  parameter int               PC_STEP  = 4,
  parameter int               SP_STEP  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] RESET_SP = WIDTH'('h1000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    ra_addr,
  output logic [WIDTH-1:0] ra_data,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] rb_data,
  input  logic             we,
  input  logic [AW-1:0]    wa_addr,
  input  logic [WIDTH-1:0] wd_data,
  input  logic             pc_en,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             br_link,
  input  logic             sp_push,
  input  logic             sp_pop,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] sp_out,
  output logic [WIDTH-1:0] lr_out,
  output logic             wr_err
);

  // Index bits needed to address the GPR array itself; the slice keeps the
  // array select exactly as wide as the array.
  localparam int GI = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

  // Comparisons are done one bit wider than the index so that a register
  // count equal to 2**AW is still representable.
  localparam logic [AW:0] GPR_LIMIT = (AW + 1)'(NUM_GPR);
  localparam logic [AW:0] REG_LIMIT = (AW + 1)'(NUM_GPR + 3);

  localparam logic [AW-1:0] SP_IDX = AW'(NUM_GPR);
  localparam logic [AW-1:0] LR_IDX = AW'(NUM_GPR + 1);
  localparam logic [AW-1:0] PC_IDX = AW'(NUM_GPR + 2);

  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0] SP_INC = WIDTH'(SP_STEP);

  logic [WIDTH-1:0] gpr [NUM_GPR];
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] sp_q;
  logic [WIDTH-1:0] lr_q;
  logic             err_q;

  logic             wr_gpr;
  logic             wr_sp;
  logic             wr_lr;
  logic             wr_pc;
  logic             wr_bad;
  logic             link_take;
  logic             lr_wr_eff;

  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] sp_next;
  logic [WIDTH-1:0] lr_next;

  logic [AW-1:0]    rd_addr [2];
  logic [WIDTH-1:0] rd_data [2];

  // Write-port decode. A link in the same cycle outranks a write to LR, so
  // the effective LR write is masked before it feeds both state and bypass.
  always_comb begin
    wr_gpr    = we && ({1'b0, wa_addr} < GPR_LIMIT);
    wr_sp     = we && (wa_addr == SP_IDX);
    wr_lr     = we && (wa_addr == LR_IDX);
    wr_pc     = we && (wa_addr == PC_IDX);
    wr_bad    = we && ({1'b0, wa_addr} >= REG_LIMIT);
    link_take = br_valid && br_link;
    lr_wr_eff = wr_lr && !link_take;
  end

  // PC next state: branch, then explicit write, then sequential advance.
  always_comb begin
    pc_next = pc_q;
    if (br_valid) begin
      pc_next = br_target;
    end else if (wr_pc) begin
      pc_next = wd_data;
    end else if (pc_en) begin
      pc_next = pc_q + PC_INC;
    end
  end

  // LR next state. The link value is taken from the PC before this edge.
  always_comb begin
    lr_next = lr_q;
    if (link_take) begin
      lr_next = pc_q + PC_INC;
    end else if (wr_lr) begin
      lr_next = wd_data;
    end
  end

  // SP next state. An explicit write drops any push/pop in the same cycle,
  // and a simultaneous push and pop cancel out.
  always_comb begin
    sp_next = sp_q;
    if (wr_sp) begin
      sp_next = wd_data;
    end else if (sp_push && !sp_pop) begin
      sp_next = sp_q - SP_INC;
    end else if (sp_pop && !sp_push) begin
      sp_next = sp_q + SP_INC;
    end
  end

  // General registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_GPR; i++) begin
        gpr[i] <= '0;
      end
    end else if (wr_gpr) begin
      gpr[wa_addr[GI-1:0]] <= wd_data;
    end
  end

  // Special registers and the invalid-write flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_PC;
      sp_q  <= RESET_SP;
      lr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_next;
      sp_q  <= sp_next;
      lr_q  <= lr_next;
      err_q <= wr_bad;
    end
  end

  assign rd_addr[0] = ra_addr;
  assign rd_addr[1] = rb_addr;

  // Read ports. A write that lands this cycle is forwarded so the datapath
  // never sees a stale value, except for PC (always the registered value)
  // and for LR when a link is overriding the write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if ({1'b0, rd_addr[p]} < GPR_LIMIT) begin
        if (wr_gpr && (wa_addr == rd_addr[p])) begin
          rd_data[p] = wd_data;
        end else begin
          rd_data[p] = gpr[rd_addr[p][GI-1:0]];
        end
      end else if (rd_addr[p] == SP_IDX) begin
        rd_data[p] = wr_sp ? wd_data : sp_q;
      end else if (rd_addr[p] == LR_IDX) begin
        rd_data[p] = lr_wr_eff ? wd_data : lr_q;
      end else if (rd_addr[p] == PC_IDX) begin
        rd_data[p] = pc_q;
      end
    end
  end

  assign ra_data = rd_data[0];
  assign rb_data = rd_data[1];
  assign pc_out  = pc_q;
  assign sp_out  = sp_q;
  assign lr_out  = lr_q;
  assign wr_err  = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank
// Self-checking bench for reg_bank, built with NUM_GPR=8 / AW=4 so that
// indices 11..15 are invalid. A reference model holds every register in one
// flat array and applies the register-bank rules directly each cycle.
module tb_reg_bank;

  localparam int W    = 32;
  localparam int NG   = 8;
  localparam int AWD  = 4;
  localparam int SP_I = NG;
  localparam int LR_I = NG + 1;
  localparam int PC_I = NG + 2;
  localparam int NREG = NG + 3;

  logic           clk;
  logic           rst;
  logic [AWD-1:0] ra_addr;
  logic [W-1:0]   ra_data;
  logic [AWD-1:0] rb_addr;
  logic [W-1:0]   rb_data;
  logic           we;
  logic [AWD-1:0] wa_addr;
  logic [W-1:0]   wd_data;
  logic           pc_en;
  logic           br_valid;
  logic [W-1:0]   br_target;
  logic           br_link;
  logic           sp_push;
  logic           sp_pop;
  logic [W-1:0]   pc_out;
  logic [W-1:0]   sp_out;
  logic [W-1:0]   lr_out;
  logic           wr_err;

  logic [W-1:0]   m_reg [NREG];
  logic           m_err;

  int checks = 0;
  int errors = 0;

  reg_bank #(
    .WIDTH   (W),
    .NUM_GPR (NG),
    .AW      (AWD),
    .PC_STEP (4),
    .SP_STEP (4),
    .RESET_PC(32'h0),
    .RESET_SP(32'h1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (ra_addr),
    .ra_data  (ra_data),
    .rb_addr  (rb_addr),
    .rb_data  (rb_data),
    .we       (we),
    .wa_addr  (wa_addr),
    .wd_data  (wd_data),
    .pc_en    (pc_en),
    .br_valid (br_valid),
    .br_target(br_target),
    .br_link  (br_link),
    .sp_push  (sp_push),
    .sp_pop   (sp_pop),
    .pc_out   (pc_out),
    .sp_out   (sp_out),
    .lr_out   (lr_out),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < NREG; i++) m_reg[i] = '0;
    m_reg[SP_I] = 32'h1000;
    m_reg[PC_I] = 32'h0;
    m_err = 1'b0;
  endtask

  // What a read of index addr must show right now: the stored value, or
  // the value being written this cycle when forwarding applies.
  function automatic logic [W-1:0] modelRead(input int addr);
    logic [W-1:0] v;
    v = '0;
    if (addr < NREG) v = m_reg[addr];
    if (we && int'(wa_addr) == addr && addr < NREG && addr != PC_I &&
        !(addr == LR_I && br_valid && br_link))
      v = wd_data;
    return v;
  endfunction

  // Drive one cycle of inputs and check both read ports against the model.
  task automatic applyStimulus(input logic s_we, input int s_wa, input logic [W-1:0] s_wd,
                               input logic s_pc_en, input logic s_brv, input logic [W-1:0] s_tgt,
                               input logic s_brl, input logic s_push, input logic s_pop,
                               input int s_ra, input int s_rb);
    we        = s_we;
    wa_addr   = AWD'(s_wa);
    wd_data   = s_wd;
    pc_en     = s_pc_en;
    br_valid  = s_brv;
    br_target = s_tgt;
    br_link   = s_brl;
    sp_push   = s_push;
    sp_pop    = s_pop;
    ra_addr   = AWD'(s_ra);
    rb_addr   = AWD'(s_rb);
    #1;
    checkOutput($sformatf("ra_data[%0d]", s_ra), ra_data, modelRead(s_ra));
    checkOutput($sformatf("rb_data[%0d]", s_rb), rb_data, modelRead(s_rb));
  endtask

  // Advance the model by the register-bank rules, clock the DUT and compare
  // the registered outputs.
  task automatic clockStep();
    logic [W-1:0] nxt [NREG];
    int wa;
    nxt = m_reg;
    wa  = int'(wa_addr);
    if (we && wa < NG) nxt[wa] = wd_data;

    if (br_valid)                nxt[PC_I] = br_target;
    else if (we && wa == PC_I)   nxt[PC_I] = wd_data;
    else if (pc_en)              nxt[PC_I] = m_reg[PC_I] + 4;

    if (br_valid && br_link)     nxt[LR_I] = m_reg[PC_I] + 4;
    else if (we && wa == LR_I)   nxt[LR_I] = wd_data;

    if (we && wa == SP_I)        nxt[SP_I] = wd_data;
    else if (sp_push && !sp_pop) nxt[SP_I] = m_reg[SP_I] - 4;
    else if (sp_pop && !sp_push) nxt[SP_I] = m_reg[SP_I] + 4;

    @(posedge clk);
    #1;
    m_reg = nxt;
    m_err = we && (wa >= NREG);
    checkOutput("pc_out", pc_out, m_reg[PC_I]);
    checkOutput("sp_out", sp_out, m_reg[SP_I]);
    checkOutput("lr_out", lr_out, m_reg[LR_I]);
    checkOutput("wr_err", {31'b0, wr_err}, {31'b0, m_err});
  endtask

  task automatic idle(input int ra, input int rb);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  initial begin
    logic [W-1:0] rnd_wd;
    logic [W-1:0] rnd_tgt;
    int           rnd_wa;
    int           rnd_ra;

    rst = 1'b0;
    we = 0; wa_addr = '0; wd_data = '0; pc_en = 0; br_valid = 0;
    br_target = '0; br_link = 0; sp_push = 0; sp_pop = 0;
    ra_addr = '0; rb_addr = '0;
    resetModel();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // PC sequencing and branch-and-link with a colliding PC write.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, PC_I, LR_I);
      clockStep();
      checkOutput($sformatf("seq_pc%0d", i), pc_out, 32'(4 * i));
    end
    applyStimulus(1, PC_I, 32'h1234, 0, 1, 32'h200, 1, 0, 0, PC_I, LR_I);
    clockStep();
    checkOutput("br_pc", pc_out, 32'h200);
    checkOutput("br_lr", lr_out, 32'h10);

    // Stack adjustment.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, SP_I, 0);
    clockStep();
    checkOutput("sp_push1", sp_out, 32'hFFC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, SP_I, 0);
    clockStep();
    checkOutput("sp_push2", sp_out, 32'hFF8);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, SP_I, 0);
    clockStep();
    checkOutput("sp_pushpop", sp_out, 32'hFF8);
    applyStimulus(1, SP_I, 32'h50, 0, 0, 0, 0, 0, 1, SP_I, SP_I);
    checkOutput("sp_bypass", ra_data, 32'h50);
    clockStep();
    checkOutput("sp_wr_pop", sp_out, 32'h50);
    applyStimulus(1, SP_I, 32'h0, 0, 0, 0, 0, 0, 0, SP_I, 0);
    clockStep();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, SP_I, 0);
    clockStep();
    checkOutput("sp_wrap", sp_out, 32'hFFFF_FFFC);

    // Forwarding rules.
    applyStimulus(1, 5, 32'hDEAD, 0, 0, 0, 0, 0, 0, 5, 5);
    checkOutput("byp_ra", ra_data, 32'hDEAD);
    checkOutput("byp_rb", rb_data, 32'hDEAD);
    clockStep();
    applyStimulus(1, PC_I, 32'h777, 0, 0, 0, 0, 0, 0, PC_I, 5);
    checkOutput("byp_pc_old", ra_data, 32'h200);
    clockStep();
    checkOutput("pc_written", pc_out, 32'h777);
    applyStimulus(1, LR_I, 32'h999, 0, 1, 32'h300, 1, 0, 0, 0, LR_I);
    checkOutput("byp_lr_old", rb_data, 32'h10);
    clockStep();
    checkOutput("lr_link_wins", lr_out, 32'h77B);

    // Invalid index write.
    applyStimulus(1, 12, 32'hABCD, 0, 0, 0, 0, 0, 0, 12, 5);
    checkOutput("inv_read", ra_data, 32'h0);
    clockStep();
    checkOutput("inv_err", {31'b0, wr_err}, 32'h1);
    idle(5, 12);
    checkOutput("inv_gpr5", ra_data, 32'hDEAD);
    clockStep();
    checkOutput("inv_err_clr", {31'b0, wr_err}, 32'h0);

    // PC wrap.
    applyStimulus(1, PC_I, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0);
    clockStep();
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0, PC_I, 0);
    clockStep();
    checkOutput("pc_wrap", pc_out, 32'h0);

    // Asynchronous reset asserted mid-cycle after some GPR activity.
    for (int i = 0; i < NG; i++) begin
      applyStimulus(1, i, 32'h100 + 32'(i), 1, 0, 0, 0, 1, 0, i, 0);
      clockStep();
    end
    idle(0, 0);
    #2;
    rst = 1'b0;
    #1;
    resetModel();
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_sp", sp_out, 32'h1000);
    checkOutput("rst_lr", lr_out, 32'h0);
    for (int i = 0; i < NG; i++) begin
      ra_addr = AWD'(i);
      #0.1;
      checkOutput($sformatf("rst_gpr%0d", i), ra_data, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomised traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rnd_wd  = $urandom;
      rnd_tgt = $urandom & 32'hFFFF_FFFC;
      rnd_wa  = $urandom_range(0, 15);
      rnd_ra  = ($urandom_range(0, 1) == 1) ? rnd_wa : $urandom_range(0, 15);
      applyStimulus($urandom_range(0, 99) < 45, rnd_wa, rnd_wd,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, rnd_tgt,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, rnd_ra, $urandom_range(0, 15));
      clockStep();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
